// File: rtl/vga_text_timing.sv
// VGA 640x480@60 timing generator and text-cell address front end.
// Every pixel reaches the outputs three clocks after its counters, aligned with the character code.
module vga_text_timing #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int TEXT_COLS = 80,
   parameter int TEXT_ROWS = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  scroll_row,
   input  logic [7:0]  text_data,
   output logic [11:0] text_addr,
   output logic        hsync,
   output logic        vsync,
   output logic        VGA_blank,
   output logic [7:0]  caracter,
   output logic [2:0]  columna,
   output logic [3:0]  fila,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam logic [11:0] COLS_L = 12'(TEXT_COLS);

   typedef struct packed {
      logic       blank;
      logic       hs;
      logic       vs;
      logic       fs;
      logic [2:0] col;
      logic [3:0] row;
   } pix_t;

   localparam pix_t PIX_IDLE = '{blank: 1'b1, hs: 1'b0, vs: 1'b0, fs: 1'b0, col: 3'd0, row: 4'd0};

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [4:0]    scroll_q, scroll_d;
   logic [11:0]   addr_q, addr_d;
   logic [7:0]    char_q;
   pix_t          pix1_q, pix2_q, pix3_q, pix_d;

   logic          frame_top;
   logic          active;
   logic [4:0]    cell_row;
   logic [5:0]    row_sum;
   logic [5:0]    trow;
   logic [11:0]   row_base;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // The scroll value sampled at (0,0) must already steer that pixel's address.
   always_comb begin
      frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
      scroll_d  = scroll_q;
      if (frame_top) begin
         scroll_d = (scroll_row >= 5'(TEXT_ROWS)) ? 5'd0 : scroll_row;
      end
   end

   always_comb begin
      active   = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
      cell_row = 5'(v_cnt_q >> 4);
      row_sum  = {1'b0, cell_row} + {1'b0, scroll_d};
      trow     = (row_sum >= 6'(TEXT_ROWS)) ? row_sum - 6'(TEXT_ROWS) : row_sum;
      // Constant multiply as shift-add; with 80 columns this is (trow<<6)+(trow<<4).
      row_base = '0;
      for (int b = 0; b < 12; b++) begin
         if (COLS_L[b]) row_base = row_base + (12'(trow) << b);
      end
      addr_d = active ? row_base + 12'(7'(h_cnt_q >> 3)) : 12'd0;

      pix_d.blank = ~active;
      pix_d.hs    = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                    (h_cnt_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
      pix_d.vs    = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                    (v_cnt_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
      pix_d.fs    = frame_top;
      pix_d.col   = active ? h_cnt_q[2:0] : 3'd0;
      pix_d.row   = active ? v_cnt_q[3:0] : 4'd0;
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      if (!rst_n) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         scroll_q <= '0;
         addr_q   <= '0;
         pix1_q   <= PIX_IDLE;
         pix2_q   <= PIX_IDLE;
         pix3_q   <= PIX_IDLE;
         char_q   <= '0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         scroll_q <= scroll_d;
         addr_q   <= addr_d;
         pix1_q   <= pix_d;
         pix2_q   <= pix1_q;
         pix3_q   <= pix2_q;
         char_q   <= pix2_q.blank ? 8'd0 : text_data;
      end
   end

   assign text_addr   = addr_q;
   assign hsync       = ~pix3_q.hs;
   assign vsync       = ~pix3_q.vs;
   assign VGA_blank   = pix3_q.blank;
   assign caracter    = char_q;
   assign columna     = pix3_q.col;
   assign fila        = pix3_q.row;
   assign frame_start = pix3_q.fs;

endmodule

// File: tb/tb_vga_text_timing.sv
// Bench for vga_text_timing: a reduced-geometry instance checked every cycle against a frame-level
// model, plus a default-geometry instance pinned with hand-computed addresses and pixel outputs.
`timescale 1ns/1ps
module tb_vga_text_timing;

   // Reduced geometry keeps whole frames short: 96 x 108 clocks, 8 x 6 text cells.
   localparam int HA = 64, HFP = 8, HS = 16, HBP = 8;
   localparam int VA = 96, VFP = 4, VS = 2, VBP = 6;
   localparam int COLS = 8, ROWS = 6;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n, rst_n_f;
   logic [4:0]  scroll_row, scroll_row_f;
   logic [7:0]  text_data = 8'd0, text_data_f = 8'd0;
   logic [11:0] text_addr, text_addr_f;
   logic        hsync, vsync, blank, frame_start;
   logic        hsync_f, vsync_f, blank_f, frame_start_f;
   logic [7:0]  caracter, caracter_f;
   logic [2:0]  columna, columna_f;
   logic [3:0]  fila, fila_f;

   int n_tests = 0, n_fail = 0;
   int age = 0, age_f = 0;
   int fscroll[8] = '{default: 0};
   bit cmp_en = 1'b0, mid_done = 1'b0;
   int hs_low = 0, vs_low = 0;
   int fs_ages[$];

   vga_text_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .TEXT_COLS(COLS), .TEXT_ROWS(ROWS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .scroll_row(scroll_row), .text_data(text_data),
      .text_addr(text_addr), .hsync(hsync), .vsync(vsync), .VGA_blank(blank),
      .caracter(caracter), .columna(columna), .fila(fila), .frame_start(frame_start)
   );

   vga_text_timing dut_f (
      .clk(clk), .rst_n(rst_n_f), .scroll_row(scroll_row_f), .text_data(text_data_f),
      .text_addr(text_addr_f), .hsync(hsync_f), .vsync(vsync_f), .VGA_blank(blank_f),
      .caracter(caracter_f), .columna(columna_f), .fila(fila_f), .frame_start(frame_start_f)
   );

   always #20 clk = ~clk;

   // Registered text RAM: data is the low byte of the address, one clock later.
   always @(posedge clk) begin
      text_data   <= text_addr[7:0];
      text_data_f <= text_addr_f[7:0];
   end

   // age = index of the pixel whose counters are live this cycle, counted from reset release.
   always @(posedge clk) begin
      if (!rst_n) age <= 0;
      else begin
         if (age % FRAME == 0) fscroll[(age / FRAME) % 8] <= (scroll_row >= ROWS) ? 0 : int'(scroll_row);
         age <= age + 1;
      end
      if (!rst_n_f) age_f <= 0;
      else          age_f <= age_f + 1;
   end

   function automatic int pix_addr(int p);
      int pos = p % FRAME;
      int x = pos % HT;
      int y = pos / HT;
      int s = fscroll[(p / FRAME) % 8];
      if (x < HA && y < VA) return ((y / 16 + s) % ROWS) * COLS + x / 8;
      return 0;
   endfunction

   function automatic logic [18:0] pix_out(int p);
      int   pos = p % FRAME;
      int   x = pos % HT;
      int   y = pos / HT;
      logic act, hs, vs;
      act = (x < HA) && (y < VA);
      hs  = (x >= HA + HFP) && (x < HA + HFP + HS);
      vs  = (y >= VA + VFP) && (y < VA + VFP + VS);
      return {~hs, ~vs, ~act, act ? 8'(pix_addr(p)) : 8'd0,
              act ? 3'(x % 8) : 3'd0, act ? 4'(y % 16) : 4'd0, pos == 0};
   endfunction

   function automatic logic [30:0] expect_out(int a);
      logic [11:0] ea;
      logic [18:0] ep;
      ea = (a >= 1) ? 12'(pix_addr(a - 1)) : 12'd0;
      ep = {1'b1, 1'b1, 1'b1, 8'd0, 3'd0, 4'd0, 1'b0};
      if (a >= 3) ep = pix_out(a - 3);
      return {ea, ep};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (age %0d, age_f %0d)", name, act, exp, age, age_f);
      end
   endtask

   task automatic wait_age(input int n);
      while (age != n) @(negedge clk);
   endtask

   task automatic wait_age_f(input int n);
      while (age_f != n) @(negedge clk);
   endtask

   // Per-cycle comparison of the reduced instance, plus first-frame sync statistics.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("pixel_stream", {1'b0, text_addr, hsync, vsync, blank, caracter, columna, fila, frame_start},
               {1'b0, expect_out(age)});
         if (!mid_done && age >= 3 && age < 3 + FRAME) begin
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
         end
         if (!mid_done && frame_start) fs_ages.push_back(age);
      end
   end

   task automatic small_seq();
      repeat (3) @(negedge clk);
      check("reset_outputs", {text_addr, hsync, vsync, blank, caracter, columna, fila, frame_start},
            {12'd0, 1'b1, 1'b1, 1'b1, 8'd0, 3'd0, 4'd0, 1'b0});
      cmp_en = 1'b1;
      rst_n  = 1'b1;
      wait_age(1);     check("addr_origin", text_addr, 0);
      wait_age(5000);  scroll_row = 5'd5;
      wait_age(9184);  check("addr_last_cell", text_addr, 47);
      wait_age(10369); check("addr_scroll5_top", text_addr, 40);
      wait_age(10372);
      check("fs_count", fs_ages.size(), 2);
      check("fs_first", (fs_ages.size() > 0) ? fs_ages[0] : -1, 3);
      check("fs_second", (fs_ages.size() > 1) ? fs_ages[1] : -1, 3 + FRAME);
      check("hsync_low_cycles", hs_low, 1728);
      check("vsync_low_cycles", vs_low, 192);
      wait_age(11921); check("addr_scroll5_wrap", text_addr, 2);
      wait_age(15000); scroll_row = 5'd31;
      wait_age(22000); scroll_row = 5'd3;
      wait_age(22281); check("addr_scroll31_midchange", text_addr, 9);
      wait_age(24304);
      check("col_13_37", columna, 5);
      check("fila_13_37", fila, 5);
      check("blank_13_37", blank, 0);
      check("char_13_37", caracter, 17);
      wait_age(24371);
      check("blank_x80", blank, 1);
      check("char_x80", caracter, 0);
      check("col_x80", columna, 0);
      check("hsync_x80", hsync, 0);
      wait_age(35934);
      mid_done = 1'b1;
      rst_n    = 1'b0;
      @(negedge clk);
      check("midreset_outputs", {text_addr, hsync, vsync, blank, caracter, columna, fila, frame_start},
            {12'd0, 1'b1, 1'b1, 1'b1, 8'd0, 3'd0, 4'd0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      wait_age(2);     check("fs_before_restart", frame_start, 0);
      wait_age(3);     check("fs_after_restart", frame_start, 1);
      wait_age(3 + 2 * HT);
   endtask

   task automatic full_seq();
      repeat (3) @(negedge clk);
      rst_n_f = 1'b1;
      wait_age_f(1);     check("full_addr_0_0", text_addr_f, 0);
      wait_age_f(12809); check("full_addr_8_16", text_addr_f, 81);
      wait_age_f(29616);
      check("full_col_13_37", columna_f, 5);
      check("full_fila_13_37", fila_f, 5);
      check("full_blank_13_37", blank_f, 0);
      check("full_char_13_37", caracter_f, 161);
      wait_age_f(30303);
      check("full_blank_x700", blank_f, 1);
      check("full_char_x700", caracter_f, 0);
      check("full_col_x700", columna_f, 0);
      check("full_hsync_x700", hsync_f, 0);
      scroll_row_f = 5'd5;
      rst_n_f      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n_f = 1'b1;
      wait_age_f(1);   check("full_scroll5_0_0", text_addr_f, 400);
      wait_age_f(9);   check("full_scroll5_8_0", text_addr_f, 401);
      wait_age_f(640); check("full_scroll5_639_0", text_addr_f, 479);
   endtask

   initial begin
      rst_n        = 1'b0;
      rst_n_f      = 1'b0;
      scroll_row   = 5'd0;
      scroll_row_f = 5'd0;
      fork
         small_seq();
         full_seq();
      join
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: time limit reached at age %0d, age_f %0d", age, age_f);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vga_text_timing.md
Name: vga_text_timing

Overview:
- Front end of the VGA text pipeline. Generates 640x480@60 pixel timing and maps each active pixel onto an 80x30 grid of 8x16 character cells.
- Reads character codes from the text buffer RAM.
- Presents the downstream text renderer with aligned hsync, vsync, blank, character code, cell column and cell row, one set per pixel clock.
- Supports whole-frame vertical scrolling with a row offset that is latched once per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- TEXT_COLS, 80, character columns
- TEXT_ROWS, 30, character rows

Ports:
- clk  in  1  pixel clock (25 MHz nominal)
- rst_n  in  1  synchronous active-low reset
- scroll_row  in  5  first text row shown at screen top; sampled at frame start
- text_data  in  8  text RAM read data; registered RAM, 1-cycle read latency
- text_addr  out  12  text RAM read address
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- VGA_blank  out  1  high outside the active area
- caracter  out  8  character code for the current pixel
- columna  out  3  pixel column within the cell (x mod 8)
- fila  out  4  pixel row within the cell (y mod 16)
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0)

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800, then wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, where V_TOTAL = 525, then wraps to 0.
  - Coordinates are x = h_cnt, y = v_cnt.
- Region decode, per counter state:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491
- Scroll latch:
  - At h_cnt == 0 && v_cnt == 0, scroll_q <= scroll_row, or 0 if scroll_row >= TEXT_ROWS.
  - scroll_q is constant for the rest of the frame; a mid-frame change to scroll_row has no effect until the next frame.
- Address generation:
  - Cycle t+1 (registered): text_addr = trow*80 + x[9:3], where trow = y[8:4] + scroll_q, minus 30 if the sum is >= 30 (wrap). Range 0..2399.
  - Outside the active area, text_addr = 0.
  - The multiply by 80 is implemented as (trow<<6) + (trow<<4).
- Pipeline and latency:
  - A pixel whose counters are presented in cycle t appears on all outputs in cycle t+3.
  - t+1: text_addr registered.
  - t+2: RAM presents text_data.
  - t+3: caracter <= text_data.
  - hsync, vsync, VGA_blank, columna (x[2:0]), fila (y[3:0]) and frame_start pass through 3-stage delay lines so they are exactly aligned with caracter.
- Output values:
  - In blanking, caracter, columna and fila output 0.
  - hsync = ~hs and vsync = ~vs, both delayed 3 cycles.
- Reset (rst_n low at a rising edge):
  - h_cnt = v_cnt = 0, scroll_q = 0, all delay-line stages cleared to the blank state.
  - Outputs on the next cycle: text_addr = 0, hsync = 1, vsync = 1, VGA_blank = 1, caracter = 0, columna = 0, fila = 0, frame_start = 0.
  - Reset mid-frame aborts the frame. The first cycle after release is counter (0,0), so the scroll latch fires, and frame_start appears 3 cycles after release.
  - Delay lines emit blank/deasserted sync until real data arrives.
- Boundaries:
  - x = 639 to 640: VGA_blank rises at the output 3 cycles later.
  - Last text column, x = 632..639: x[9:3] = 79.
  - Last text row, y = 464..479: y[8:4] = 29.
  - Lines 480..524 are blank for the whole line; vsync is low only on output lines 490..491.

Test Plan:
- Reset then run 1 frame -> frame_start pulses exactly once, 3 cycles after release; 420000 cycles later it pulses again; hsync low for 96 cycles per 800; vsync low for 1600 cycles per frame.
- scroll_row = 0, RAM model returning addr[7:0] -> at counter (0,0) text_addr = 0; at (639,479) text_addr = 2399; at (8,16) text_addr = 81; caracter equals the model data with latency 3.
- scroll_row = 5 -> y = 400 (row 25) gives trow 0 and text_addr = x>>3; y = 0 gives text_addr = 400.
- scroll_row = 31 -> treated as 0; change scroll_row mid-frame -> addresses unchanged until the next frame.
- Pixel x = 13, y = 37 -> columna = 5, fila = 5, VGA_blank = 0 on the same output cycle; x = 700 -> VGA_blank = 1, caracter = 0, columna = 0.
- Assert rst_n low at counter (300,200) for 2 cycles -> next cycle outputs match reset values; after release, counters restart at (0,0) with no partial sync pulse emitted.
